// File: rtl/nco_wave_gen.sv
// Select-driven NCO waveform generator.
// A 5-bit phase counter walks a fixed 32-sample table for the selected waveform.
// wave_out is registered from the current (select, phase) pair. After an accepted
// select change, sample 0 of the new waveform appears two edges later.
// Optional feature: define NCO_SEL_LOCK_EN to reject select changes for 31 cycles
// after each accepted change and to flag new rejected changes on sel_viol.
module nco_wave_gen #(
    parameter int unsigned SELECT_WIDTH = 3,
    parameter int unsigned WAVE_WIDTH   = 8,
    parameter int unsigned PHASE_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [SELECT_WIDTH-1:0] signal_out,
    output logic [WAVE_WIDTH-1:0]   wave_out,
    output logic [PHASE_WIDTH-1:0]  phase,
    output logic                    sel_viol
);

    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic [WAVE_WIDTH-1:0]   wave_q, wave_d;
    logic                    chg;
    logic                    accept;

    // Sine offsets from mid-scale for the first quarter wave (k = 0..8).
    function automatic logic [7:0] sine_quarter(input logic [3:0] m);
        logic [7:0] q;
        case (m)
            4'd0:    q = 8'd0;
            4'd1:    q = 8'd25;
            4'd2:    q = 8'd49;
            4'd3:    q = 8'd71;
            4'd4:    q = 8'd90;
            4'd5:    q = 8'd106;
            4'd6:    q = 8'd117;
            4'd7:    q = 8'd125;
            4'd8:    q = 8'd127;
            default: q = 8'd0;
        endcase
        return q;
    endfunction

    // Full sine from the quarter table; offsets are symmetric because no point rounds at .5.
    function automatic logic [7:0] sine_at(input logic [4:0] k);
        logic [3:0] m;
        logic [7:0] q;
        m = k[3:0];
        // Second quarter mirrors the first: offset index is 16 - m (mod 16).
        q = (m <= 4'd8) ? sine_quarter(m) : sine_quarter(4'd0 - m);
        return k[4] ? (8'd128 - q) : (8'd128 + q);
    endfunction

    function automatic logic [7:0] table_sample(input logic [SELECT_WIDTH-1:0] sel,
                                                input logic [4:0]              k);
        logic [7:0] s;
        logic [3:0] tri_idx;
        tri_idx = k[4] ? ~k[3:0] : k[3:0];
        if (32'(sel) > 32'd7) begin
            s = 8'd0;
        end else begin
            case (sel[2:0])
                3'd0:    s = sine_at(k);
                3'd1:    s = sine_at(k + 5'd8);
                3'd2:    s = 8'({4'b0000, tri_idx}) * 8'd17;
                3'd3:    s = {k, 3'b000};
                3'd4:    s = k[4] ? 8'd0 : 8'd255;
                3'd5:    s = ~{k, 3'b000};
                default: s = 8'd0;
            endcase
        end
        return s;
    endfunction

    assign chg = (signal_out != sel_q);

`ifdef NCO_SEL_LOCK_EN
    logic [4:0]              lock_q, lock_d;
    logic [SELECT_WIDTH-1:0] prev_q;
    logic                    viol_q, viol_d;

    // Lock window: accept only when idle; flag a rejected change once, when the input moves.
    always_comb begin
        accept = chg && (lock_q == 5'd0);
        viol_d = chg && (lock_q != 5'd0) && (signal_out != prev_q);
        lock_d = lock_q;
        if (accept) begin
            lock_d = 5'd31;
        end else if (lock_q != 5'd0) begin
            lock_d = lock_q - 5'd1;
        end
    end

    // Lock counter, previous input and violation pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q <= 5'd0;
            prev_q <= '0;
            viol_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            prev_q <= signal_out;
            viol_q <= viol_d;
        end
    end

    assign sel_viol = viol_q;
`else
    assign accept   = chg;
    assign sel_viol = 1'b0;
`endif

    // Next state: restart phase on an accepted change, otherwise advance one sample.
    always_comb begin
        sel_d   = sel_q;
        phase_d = phase_q + PHASE_WIDTH'(1);
        if (accept) begin
            sel_d   = signal_out;
            phase_d = '0;
        end
        // 8-bit sample MSB-aligned with zero LSB fill.
        wave_d = WAVE_WIDTH'(table_sample(sel_q, phase_q)) << (WAVE_WIDTH - 8);
    end

    // Select, phase and output sample registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q   <= '0;
            phase_q <= '0;
            wave_q  <= '0;
        end else begin
            sel_q   <= sel_d;
            phase_q <= phase_d;
            wave_q  <= wave_d;
        end
    end

    assign wave_out = wave_q;
    assign phase    = phase_q;

endmodule
